// File: rtl/s2p_frame_ctrl.sv
// ---------------------------------------------------------------------------
// s2p_frame_ctrl
// Framing controller and receive sequencer for a one-bit-per-clock serial
// line. It detects a start bit, collects WIDTH data bits (LSB first), checks
// an optional parity bit and the stop bit, and then hands the assembled word
// to a downstream consumer over a valid/ready handshake.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-low
//   serial_in   serial line, idle level 1
//   enable      1 = a new frame may start (gates IDLE->DATA only)
//   data_ready  consumer accepts data_out this cycle
//   err_clr     clears the sticky error flags (a same-cycle event wins)
//   data_out    last accepted word
//   data_valid  data_out holds an unconsumed word
//   busy        receiver is outside IDLE
//   frame_err   sticky, stop bit sampled as 0
//   parity_err  sticky, parity mismatch on an otherwise good frame
//   overrun     sticky, good word dropped because the holding reg was full
// ---------------------------------------------------------------------------
module s2p_frame_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             enable,
  input  logic             data_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_par_bad;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_busy;
  logic             r_frame_err;
  logic             r_parity_err;
  logic             r_overrun;

  logic w_last_bit;
  logic w_par_bad;
  logic w_stop;
  logic w_good;
  logic w_par_evt;
  logic w_frm_evt;
  logic w_load;
  logic w_drop;

  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));
  // XOR of data and parity bit must equal 1 for odd parity, 0 for even.
  assign w_par_bad  = ((^r_shift) ^ serial_in) != (PARITY_ODD != 0);
  assign w_stop     = (r_state == S_STOP);
  assign w_good     = w_stop &&  serial_in && !r_par_bad;
  assign w_par_evt  = w_stop &&  serial_in &&  r_par_bad;
  assign w_frm_evt  = w_stop && !serial_in;
  assign w_load     = w_good && (!r_data_valid || data_ready);
  assign w_drop     = w_good &&  r_data_valid && !data_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable && !serial_in) begin
            r_state   <= S_DATA;
            r_cnt     <= '0;
            r_par_bad <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_DATA: begin
          // Right-shift entry: after WIDTH bits the first-received bit sits
          // in bit 0, equivalent to writing bit [counter] LSB first.
          r_shift <= {serial_in, r_shift[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last_bit) begin
            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          r_par_bad <= w_par_bad;
          r_state   <= S_STOP;
        end
        S_STOP: begin
          if (serial_in) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (serial_in) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A load in the same cycle as an accept keeps data_valid high.
      if (w_load) begin
        r_data_out   <= r_shift;
        r_data_valid <= 1'b1;
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end

      r_frame_err  <= (r_frame_err  && !err_clr) || w_frm_evt;
      r_parity_err <= (r_parity_err && !err_clr) || w_par_evt;
      r_overrun    <= (r_overrun    && !err_clr) || w_drop;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Framing controller and receive sequencer for the 4-bit serial-to-parallel path. It detects a start bit on a one-bit-per-clock serial line and counts WIDTH data bits, LSB first. It then checks an optional parity bit and the stop bit, and presents the assembled word through a valid/ready handshake. It sits between the raw serial input and the downstream word consumer, and reports framing, parity and overrun errors.

Parameters:
WIDTH, 4, number of data bits per frame (2..16)
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity (data bits XOR parity bit = 0); 1 = odd parity (XOR = 1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-low
serial_in  input  1  serial line; idle level 1; sampled once per clk
enable  input  1  1 = start-bit detection allowed; 0 = no new frame starts
data_ready  input  1  consumer accepts data_out this cycle
err_clr  input  1  clears the sticky error flags
data_out  output  WIDTH  last accepted word
data_valid  output  1  data_out holds an unconsumed word
busy  output  1  FSM is outside IDLE
frame_err  output  1  sticky; a stop bit was sampled as 0
parity_err  output  1  sticky; a parity mismatch was detected
overrun  output  1  sticky; a good word was dropped because the holding register was full

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, bit counter=0, shift register=0.
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, parity_err=0, overrun=0.
- Reset mid-frame aborts the frame immediately; no flag is set.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: if enable=1 and serial_in=0, go to DATA and set counter=0. Otherwise stay in IDLE.
- DATA: shift serial_in into bit [counter] of the shift register (LSB first) and increment the counter.
- DATA exit: after the WIDTH-th bit, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: compare serial_in against the parity of the data bits, then go to STOP. A mismatch is latched internally for that frame.
- STOP, serial_in=1 and no parity mismatch: the word is "good"; go to IDLE.
- STOP, serial_in=1 and parity mismatch: set parity_err, discard the word, go to IDLE.
- STOP, serial_in=0: set frame_err, discard the word (frame_err has priority over parity_err), go to BREAK.
- BREAK: stay until serial_in=1, then go to IDLE. A held-low line never retriggers a start.
- enable gates IDLE->DATA only. Deasserting enable mid-frame does not abort the frame.
- busy=1 in DATA, PARITY, STOP and BREAK.
- Good-word handling, computed in the same cycle the stop bit is sampled:
  - If data_valid=0, or data_valid=1 and data_ready=1: load data_out, set data_valid=1 on the next edge.
  - If data_valid=1 and data_ready=0: drop the word, set overrun; data_out is unchanged.
- Handshake: data_valid falls on the edge after a cycle with data_valid=1 and data_ready=1, unless a good word loads in that same cycle (then it stays 1).
- data_out stays stable while data_valid=1 and data_ready=0.
- Latency: start bit sampled at edge E0, data bits at E1..E_WIDTH, parity at E_WIDTH+1, stop at E_WIDTH+1+PARITY_EN. data_valid=1 is visible after the stop edge. For WIDTH=4 and PARITY_EN=1, the stop bit is sampled at E6.
- Back-to-back frames: a new start bit may be sampled in the cycle immediately after the stop bit (IDLE is entered at the stop edge).
- Sticky flags: cleared by err_clr=1. If err_clr=1 and a new error event occur in the same cycle, the flag stays set (set wins).
- Counter width is clog2(WIDTH+1). The counter never wraps within a frame.

Test Plan:
- Good frame, WIDTH=4, PARITY_EN=1, even, data_ready=1: serial 0,1,0,1,1,1,1 (data 4'hD, parity 1, stop 1) -> data_out=4'hD, data_valid=1 for exactly one cycle after the stop edge, no errors, busy=1 for 6 cycles.
- Parity error: serial 0,1,0,1,1,0,1 -> parity_err=1, data_valid stays 0, data_out stays 0. Then err_clr pulse -> parity_err=0.
- Frame error plus break: serial 0,0,0,1,0,1,0 followed by 0,0,0 then 1 -> frame_err=1, FSM in BREAK while the line is 0, no start detected, returns to IDLE after the 1. A later good frame is received.
- Overrun: two back-to-back good frames 4'h3 then 4'hA with data_ready=0 -> data_out=4'h3, overrun=1. Then data_ready=1 -> data_valid clears next cycle.
- Simultaneous accept and load: first frame 4'h5 held; second frame's stop edge coincides with data_ready=1 -> data_out=4'hC (second frame), data_valid stays 1, overrun=0.
- Control: enable=0 with a start bit -> stays IDLE. enable dropped mid-frame -> frame completes. rst=0 at the parity edge -> all outputs 0, the next frame decodes correctly.
